// File: rtl/vex_rdc_unit.sv
// vex_rdc_unit: pipelined log2(VECTOR_LANES)-level reduction tree with a
// head/end-controlled accumulator, a registered scalar output and full
// valid/ready backpressure.
module vex_rdc_unit #(
    parameter int VECTOR_LANES       = 8,
    parameter int DATA_WIDTH         = 32,
    parameter int VECTOR_REGISTERS   = 32,
    parameter int VECTOR_TICKET_BITS = 5
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   valid_i,
    output logic                                   ready_o,
    input  logic [VECTOR_LANES-1:0][DATA_WIDTH-1:0] data_i,
    input  logic [VECTOR_LANES-1:0]                mask_i,
    input  logic [2:0]                             op_i,
    input  logic [DATA_WIDTH-1:0]                  seed_i,
    input  logic [$clog2(VECTOR_REGISTERS)-1:0]    dst_i,
    input  logic [VECTOR_TICKET_BITS-1:0]          ticket_i,
    input  logic                                   head_uop_i,
    input  logic                                   end_uop_i,
    output logic                                   valid_o,
    input  logic                                   ready_i,
    output logic [DATA_WIDTH-1:0]                  result_o,
    output logic [$clog2(VECTOR_REGISTERS)-1:0]    dst_o,
    output logic [VECTOR_TICKET_BITS-1:0]          ticket_o,
    output logic                                   idle_o
);
    localparam int L     = $clog2(VECTOR_LANES);
    localparam int DST_W = $clog2(VECTOR_REGISTERS);

    // Identity element substituted for masked-off lanes.
    function automatic logic [DATA_WIDTH-1:0] rdc_identity(input logic [2:0] op);
        case (op)
            3'd1, 3'd4: rdc_identity = {DATA_WIDTH{1'b1}};
            3'd5:       rdc_identity = {1'b0, {(DATA_WIDTH-1){1'b1}}};
            3'd7:       rdc_identity = {1'b1, {(DATA_WIDTH-1){1'b0}}};
            default:    rdc_identity = '0;
        endcase
    endfunction

    // Binary reduction operator shared by the tree and the accumulator.
    function automatic logic [DATA_WIDTH-1:0] rdc_combine(input logic [2:0] op,
                                                          input logic [DATA_WIDTH-1:0] a,
                                                          input logic [DATA_WIDTH-1:0] b);
        case (op)
            3'd0:    rdc_combine = a + b;
            3'd1:    rdc_combine = a & b;
            3'd2:    rdc_combine = a | b;
            3'd3:    rdc_combine = a ^ b;
            3'd4:    rdc_combine = (a < b) ? a : b;
            3'd5:    rdc_combine = ($signed(a) < $signed(b)) ? a : b;
            3'd6:    rdc_combine = (a > b) ? a : b;
            default: rdc_combine = ($signed(a) > $signed(b)) ? a : b;
        endcase
    endfunction

    logic                  stall;
    logic                  transfer;
    logic                  valid_reg;
    logic                  open_reg;
    logic [DATA_WIDTH-1:0] acc_reg;
    logic [DATA_WIDTH-1:0] acc_base;
    logic [DATA_WIDTH-1:0] acc_next;
    logic [DATA_WIDTH-1:0] tree_out;
    logic [DATA_WIDTH-1:0] masked [VECTOR_LANES];

    // Per-level sideband: one entry per tree level.
    logic [L-1:0]                  vld_reg;
    logic [L-1:0]                  head_reg;
    logic [L-1:0]                  end_reg;
    logic [2:0]                    op_reg     [L];
    logic [DATA_WIDTH-1:0]         seed_reg   [L];
    logic [DST_W-1:0]              dst_reg    [L];
    logic [VECTOR_TICKET_BITS-1:0] ticket_reg [L];

    assign stall    = valid_reg & ~ready_i;
    assign ready_o  = ~stall;
    assign transfer = valid_i & ready_o;
    assign valid_o  = valid_reg;
    assign idle_o   = ~valid_reg & ~open_reg & ~(|vld_reg);

    genvar gi;
    generate
        for (gi = 0; gi < VECTOR_LANES; gi++) begin : g_mask
            assign masked[gi] = mask_i[gi] ? data_i[gi] : rdc_identity(op_i);
        end

        for (gi = 0; gi < L; gi++) begin : g_lvl
            localparam int N = VECTOR_LANES >> (gi + 1);
            logic [DATA_WIDTH-1:0] src [2*N];
            logic [DATA_WIDTH-1:0] data_reg [N];
            logic [2:0]            src_op;
            if (gi == 0) begin : g_first
                assign src    = masked;
                assign src_op = op_i;
            end else begin : g_next
                assign src    = g_lvl[gi-1].data_reg;
                assign src_op = op_reg[gi-1];
            end
            // Pairwise combine of the previous level, frozen on stall.
            always_ff @(posedge clk) begin
                if (!stall) begin
                    for (int j = 0; j < N; j++) begin
                        data_reg[j] <= rdc_combine(src_op, src[2*j], src[2*j+1]);
                    end
                end
            end
            if (gi == L - 1) begin : g_last
                assign tree_out = data_reg[0];
            end
        end
    endgenerate

    // Sideband pipeline: valid/op/dst/ticket/flags shift one level per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_reg  <= '0;
            head_reg <= '0;
            end_reg  <= '0;
            for (int k = 0; k < L; k++) begin
                op_reg[k]     <= '0;
                dst_reg[k]    <= '0;
                ticket_reg[k] <= '0;
            end
        end else if (!stall) begin
            vld_reg[0]    <= transfer;
            head_reg[0]   <= head_uop_i;
            end_reg[0]    <= end_uop_i;
            op_reg[0]     <= op_i;
            dst_reg[0]    <= dst_i;
            ticket_reg[0] <= ticket_i;
            for (int k = 1; k < L; k++) begin
                vld_reg[k]    <= vld_reg[k-1];
                head_reg[k]   <= head_reg[k-1];
                end_reg[k]    <= end_reg[k-1];
                op_reg[k]     <= op_reg[k-1];
                dst_reg[k]    <= dst_reg[k-1];
                ticket_reg[k] <= ticket_reg[k-1];
            end
        end
    end

    // Seed travels with its micro-op; it is data so it carries no reset.
    always_ff @(posedge clk) begin
        if (!stall) begin
            seed_reg[0] <= seed_i;
            for (int k = 1; k < L; k++) begin
                seed_reg[k] <= seed_reg[k-1];
            end
        end
    end

    // A head, or any micro-op with no reduction open, restarts from the seed.
    assign acc_base = (head_reg[L-1] | ~open_reg) ? seed_reg[L-1] : acc_reg;
    assign acc_next = rdc_combine(op_reg[L-1], acc_base, tree_out);

    // Running accumulator for multi-micro-op reductions.
    always_ff @(posedge clk) begin
        if (!stall && vld_reg[L-1]) begin
            acc_reg <= acc_next;
        end
    end

    // Open flag and output register; an end micro-op publishes the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            open_reg  <= 1'b0;
            valid_reg <= 1'b0;
            result_o  <= '0;
            dst_o     <= '0;
            ticket_o  <= '0;
        end else if (!stall) begin
            valid_reg <= vld_reg[L-1] & end_reg[L-1];
            if (vld_reg[L-1]) begin
                if (end_reg[L-1]) begin
                    open_reg <= 1'b0;
                    result_o <= acc_next;
                    dst_o    <= dst_reg[L-1];
                    ticket_o <= ticket_reg[L-1];
                end else begin
                    open_reg <= 1'b1;
                end
            end
        end
    end
endmodule
